// File: rtl/min_max_array_loader.sv
// min_max_array_loader: fills a DEPTH x WIDTH array over valid/ready, pulses Start when full, holds until Done.
// Optional running checksum output Chksum when MMF_LOADER_CHKSUM_EN is defined.
module min_max_array_loader #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Din,
    input  logic             Din_valid,
    output logic             Din_ready,
    input  logic [AW-1:0]    Rd_addr,
    output logic [WIDTH-1:0] Rd_data,
    output logic             Start,
    input  logic             Done,
    output logic [AW:0]      Count,
    output logic             Full,
    output logic             Qi,
    output logic             Qw,
    output logic             Qs,
    output logic             Qh
`ifdef MMF_LOADER_CHKSUM_EN
    ,
    output logic [WIDTH-1:0] Chksum
`endif
);
    typedef enum logic [3:0] {
        INI  = 4'b0001,
        WR   = 4'b0010,
        STRT = 4'b0100,
        HOLD = 4'b1000
    } state_t;
    state_t state;
    logic [WIDTH-1:0] mem [DEPTH];
    assign {Qh, Qs, Qw, Qi} = state;
    assign Din_ready = (state == WR);
    assign Start     = (state == STRT);
    assign Full      = (state == STRT) || (state == HOLD);
    assign Rd_data   = mem[Rd_addr];
    // Control and datapath: Count and contents only move on a WR transfer; array is never reset
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= INI;
            Count <= '0;
`ifdef MMF_LOADER_CHKSUM_EN
            Chksum <= '0;
`endif
        end else begin
            case (state)
                INI: begin
                    Count <= '0;
`ifdef MMF_LOADER_CHKSUM_EN
                    Chksum <= '0;
`endif
                    state <= WR;
                end
                WR: if (Din_valid) begin
                    mem[Count[AW-1:0]] <= Din;
                    Count <= Count + 1'b1;
`ifdef MMF_LOADER_CHKSUM_EN
                    Chksum <= Chksum + Din;
`endif
                    if (Count == (AW+1)'(DEPTH - 1))
                        state <= STRT;
                end
                STRT: state <= HOLD;
                HOLD: if (Done) state <= INI;
                default: state <= INI;
            endcase
        end
    end
endmodule
